// File: rtl/psr2_and_driver_if.sv
// Signal bundle between the psr2 pulse driver and its stimulus/readout side.
// The driver uses the slave modport; the operand source and result sink use master.
interface psr2_and_driver_if;
    logic in_valid;
    logic in_ready;
    logic in_a;
    logic in_b;
    logic a_out;
    logic b_out;
    logic clk_out;
    logic gate_out;
    logic res_valid;
    logic res_bit;
    logic err_spurious;
    logic err_multi;

    modport slave (
        input  in_valid, in_a, in_b, gate_out,
        output in_ready, a_out, b_out, clk_out, res_valid, res_bit, err_spurious, err_multi
    );

    modport master (
        output in_valid, in_a, in_b, gate_out,
        input  in_ready, a_out, b_out, clk_out, res_valid, res_bit, err_spurious, err_multi
    );
endinterface

// File: rtl/psr2_and_driver.sv
// RSFQ-protocol initiator for clocked psr2 AND cells: emits data pulses, a clock
// pulse after a setup gap, then captures the gate response and flags protocol errors.
module psr2_and_driver #(
    parameter int PULSE_W   = 2,
    parameter int SETUP_GAP = 4,
    parameter int RESP_WIN  = 32,
    parameter int HOLD_GAP  = 16,
    parameter int CNT_W     = 8
) (
    input  logic              clk,
    input  logic              rst,
    psr2_and_driver_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DATA  = 3'd1,
        SETUP = 3'd2,
        CLK   = 3'd3,
        RESP  = 3'd4,
        GAP   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_GAP - 1);
    localparam logic [CNT_W-1:0] RESP_LD  = CNT_W'(RESP_WIN - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_GAP - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] timer, timer_n;
    logic             op_a, op_b, op_a_n, op_b_n;
    logic             hit, hit_n;
    logic             gate_q;
    logic             rise;
    logic             last;
    logic             spurious_set;
    logic             multi_set;
    logic             res_strobe;

    assign rise         = bus.gate_out & ~gate_q;
    assign last         = (timer == '0);
    assign spurious_set = rise && (state != RESP);
    assign multi_set    = rise && (state == RESP) && hit;
    assign res_strobe   = (state == RESP) && (state_n == GAP);

    // Timer counts down to zero in every timed state and is reloaded on each entry.
    always_comb begin
        state_n = state;
        timer_n = last ? timer : timer - CNT_W'(1);
        op_a_n  = op_a;
        op_b_n  = op_b;
        hit_n   = hit;
        case (state)
            IDLE: begin
                timer_n = '0;
                if (bus.in_valid && bus.in_ready) begin
                    state_n = DATA;
                    timer_n = PULSE_LD;
                    op_a_n  = bus.in_a;
                    op_b_n  = bus.in_b;
                    hit_n   = 1'b0;
                end
            end
            DATA: begin
                if (last) begin
                    state_n = SETUP;
                    timer_n = SETUP_LD;
                end
            end
            SETUP: begin
                if (last) begin
                    state_n = CLK;
                    timer_n = PULSE_LD;
                end
            end
            CLK: begin
                if (last) begin
                    state_n = RESP;
                    timer_n = RESP_LD;
                end
            end
            RESP: begin
                hit_n = hit | rise;
                if (last) begin
                    state_n = GAP;
                    timer_n = HOLD_LD;
                end
            end
            GAP: begin
                if (last) begin
                    state_n = IDLE;
                    timer_n = '0;
                end
            end
            default: begin
                state_n = IDLE;
                timer_n = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            timer            <= '0;
            op_a             <= 1'b0;
            op_b             <= 1'b0;
            hit              <= 1'b0;
            gate_q           <= 1'b0;
            bus.in_ready     <= 1'b0;
            bus.a_out        <= 1'b0;
            bus.b_out        <= 1'b0;
            bus.clk_out      <= 1'b0;
            bus.res_valid    <= 1'b0;
            bus.res_bit      <= 1'b0;
            bus.err_spurious <= 1'b0;
            bus.err_multi    <= 1'b0;
        end else begin
            state            <= state_n;
            timer            <= timer_n;
            op_a             <= op_a_n;
            op_b             <= op_b_n;
            hit              <= hit_n;
            gate_q           <= bus.gate_out;
            bus.in_ready     <= (state_n == IDLE);
            bus.a_out        <= (state_n == DATA) && op_a_n;
            bus.b_out        <= (state_n == DATA) && op_b_n;
            bus.clk_out      <= (state_n == CLK);
            bus.res_valid    <= res_strobe;
            if (res_strobe) begin
                bus.res_bit  <= hit_n;
            end
            bus.err_spurious <= bus.err_spurious | spurious_set;
            bus.err_multi    <= bus.err_multi | multi_set;
        end
    end

endmodule
